// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM state type and a counter sizing helper.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 3;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Bits needed to hold values 0..max_val without wrapping (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command into one APB transfer and
// reports completion (read data) or a wait-state timeout on a one-cycle strobe.
//
// Handshakes: a command is taken on a rising edge where cmd_valid and cmd_ready
// are both high; cmd_ready is high exactly while the FSM is IDLE. The response
// side has no backpressure: rsp_valid is high for one cycle and rsp_err/rsp_rdata
// are valid with it.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  output apb_state_t            state_o
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  // Value of the wait counter on the edge that would be the TIMEOUT_CYCLES-th wait.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  apb_state_t            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CW-1:0]         wait_q;
  logic [CW-1:0]         wait_d;
  logic                  timeout_hit;

  // Saturating increment of the wait-state counter and the abort condition.
  always_comb begin
    wait_d      = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
    timeout_hit = TO_EN && (wait_q == TO_LAST);
  end

  // Transfer FSM with registered bus and response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            wait_q    <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a programmable-delay APB slave stub, a memory/queue
// reference model and a directed-then-random sequence of transfers.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  apb_state_t    state_o;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .state_o(state_o)
  );

  // Clock / cycle counter
  always #5 PCLK = ~PCLK;
  longint cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave stub: memory, PREADY after wait_target wait states, optional stuck-low
  // PREADY and optional fixed read data.
  logic [DW-1:0] smem [8] = '{default: '0};
  int            wait_target = 0;
  int            wcnt = 0;
  logic          hold_zero = 1'b0;
  logic          ovr_en = 1'b0;
  logic [DW-1:0] ovr_data = '0;

  assign PREADY = PSEL && PENABLE && !hold_zero && (wcnt >= wait_target);
  assign PRDATA = ovr_en ? ovr_data : smem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
  end

  // Scoreboard / reference model
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_mem [8];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge; returns at the negedge where rsp_valid is seen.
  logic [DW-1:0] r_rd;
  logic          r_err;
  int            r_psel, r_pen, r_lat;
  longint        r_acc;

  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drv_ready_wait", 32'(guard < 100), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(negedge PCLK);
    r_acc = cyc;
    cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1);
    cmd_addr = AW'($urandom_range(0, 7)); cmd_wdata = $urandom;
    r_psel = 0; r_pen = 0; r_lat = 1;
    while (!rsp_valid && r_lat < 100) begin
      if (PSEL) r_psel++;
      if (PENABLE) r_pen++;
      chk("paddr_stable", 32'(PADDR), 32'(a));
      chk("pwrite_stable", 32'(PWRITE), 32'(wr));
      if (wr) chk("pwdata_stable", PWDATA, wd);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      @(negedge PCLK);
      r_lat++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    chk("rsp_psel_low", 32'(PSEL), 32'd0);
    chk("rsp_ready_high", 32'(cmd_ready), 32'd1);
    r_rd = rsp_rdata;
    r_err = rsp_err;
  endtask

  // Model-side wrapper: queue the expected result, run, compare latency/data.
  task automatic xfer_chk(input string tag, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int waits);
    logic [DW-1:0] e;
    exp_q.push_back(wr ? '0 : (ovr_en ? ovr_data : exp_mem[a]));
    if (wr) exp_mem[a] = wd;
    wait_target = waits;
    do_xfer(wr, a, wd);
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, r_rd, e);
    chk({tag, "_err"}, 32'(r_err), 32'd0);
    chk({tag, "_lat"}, r_lat, 3 + waits);
    chk({tag, "_psel_cycles"}, r_psel, 2 + waits);
    chk({tag, "_pen_cycles"}, r_pen, 1 + waits);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  longint prev_acc;
  logic [AW-1:0] acc_a;
  logic          was_idle;

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    // Reset state
    #12;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // 1: write then read addr 2
    xfer_chk("t1_wr", 1'b1, 3'd2, 32'hDEADBEEF, 0);
    xfer_chk("t1_rd", 1'b0, 3'd2, 32'h0, 0);
    chk("t1_rd_value", r_rd, 32'hDEADBEEF);
    @(negedge PCLK);
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("t1_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // 2: back-to-back writes to 0..7 then reads, 3-cycle spacing
    prev_acc = -1;
    for (int i = 0; i < 16; i++) begin
      xfer_chk("t2", (i < 8), AW'(i % 8), 32'h1000_0000 + (i % 8), 0);
      if (i >= 8) chk("t2_readback", r_rd, 32'h1000_0000 + (i % 8));
      if (prev_acc >= 0) chk("t2_spacing", 32'(r_acc - prev_acc), 32'd3);
      prev_acc = r_acc;
    end

    // 3: three wait states, read returning fixed data
    ovr_en = 1'b1; ovr_data = 32'hCAFEF00D;
    xfer_chk("t3", 1'b0, 3'd5, 32'h0, 3);
    chk("t3_value", r_rd, 32'hCAFEF00D);
    chk("t3_pen4", r_pen, 4);
    ovr_en = 1'b0;

    // 4: PREADY stuck low -> timeout after TO ACCESS cycles
    hold_zero = 1'b1;
    do_xfer(1'b0, 3'd3, 32'h0);
    chk("t4_err", 32'(r_err), 32'd1);
    chk("t4_rdata", r_rd, 32'd0);
    chk("t4_pen_cycles", r_pen, TO);
    chk("t4_lat", r_lat, TO + 2);
    hold_zero = 1'b0;
    xfer_chk("t4_after", 1'b0, 3'd3, 32'h0, 1);

    // 5: reset in the middle of ACCESS
    hold_zero = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("t5_in_access", 32'(PENABLE), 32'd1);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("t5_psel_async", 32'(PSEL), 32'd0);
    chk("t5_pen_async", 32'(PENABLE), 32'd0);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    hold_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("t5_quiet_rsp", 32'(rsp_valid), 32'd0);
      chk("t5_ready", 32'(cmd_ready), 32'd1);
    end

    // 6: cmd_valid held high with a changing address every cycle
    was_idle = 1'b1;
    acc_a = '0;
    for (int i = 0; i < 24; i++) begin
      if (PSEL && !PENABLE) begin
        chk("t6_setup_addr", 32'(PADDR), 32'(acc_a));
        chk("t6_idle_before_setup", 32'(was_idle), 32'd1);
      end
      if (PSEL && PENABLE) chk("t6_access_addr", 32'(PADDR), 32'(acc_a));
      if (rsp_valid) begin
        chk("t6_rsp_err", 32'(rsp_err), 32'd0);
        chk("t6_rsp_rdata", rsp_rdata, 32'd0);
      end
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = AW'($urandom_range(0, 7)); cmd_wdata = $urandom;
      if (cmd_ready) begin
        acc_a = cmd_addr;
        exp_mem[cmd_addr] = cmd_wdata;
      end
      was_idle = !PSEL;
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    for (int a = 0; a < 8; a++) xfer_chk("t6_rb", 1'b0, AW'(a), 32'h0, 0);

    // Random mix of reads/writes with random wait states
    for (int i = 0; i < 20; i++) begin
      xfer_chk("rnd", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
